// File: rtl/pipe_out_block_reader.sv
// rtl/pipe_out_block_reader.sv - host-side pipe-out block reader with local FWFT buffer
//
// Polls the producer's available-word count, issues BLOCK_LEN-word read
// bursts (producer answers one cycle after each strobe), buffers the words in
// a local first-word-fall-through FIFO and re-streams them on a valid/ready
// port while keeping a delivered-word count and a wrapping checksum.
//
// Ports:
//   ti_clk            clock
//   a_rst_n           asynchronous reset, active-low
//   start             pulse, begin a transfer of num_blocks blocks (ignored while busy)
//   abort             pulse, stop issuing reads, drain, finish
//   num_blocks        blocks to read, sampled on start
//   ti_out_available  words the producer currently holds
//   ti_out_data_en    read strobe to producer, one word per high cycle
//   ti_out_data       producer word, valid the cycle after ti_out_data_en
//   m_data / m_valid / m_ready   output word stream
//   busy              transfer in progress
//   done              one-cycle pulse at end of transfer
//   word_count        words delivered since last start
//   checksum          wrapping sum of words delivered since last start
`timescale 1ns/1ps

module pipe_out_block_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int BLOCK_LEN  = 16,
  parameter int BUF_DEPTH  = 32
) (
  input  logic                  ti_clk,
  input  logic                  a_rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  num_blocks,
  input  logic [CNT_WIDTH-1:0]  ti_out_available,
  output logic                  ti_out_data_en,
  input  logic [DATA_WIDTH-1:0] ti_out_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int BW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  // A burst may start only while occupied+in-flight leaves a whole block free.
  localparam logic [PW:0]    SPACE_LIMIT = (PW+1)'(BUF_DEPTH - BLOCK_LEN);
  localparam logic [BW-1:0]  LAST_BEAT   = BW'(BLOCK_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_BURST = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_WIDTH-1:0]  r_blocks_left;
  logic [BW-1:0]         r_beat;
  logic                  r_cap_valid;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [CNT_WIDTH-1:0]  r_word_count;
  logic [DATA_WIDTH-1:0] r_checksum;

  logic [PW-1:0]         w_count;
  logic [PW:0]           w_reserved;
  logic                  w_space_ok;
  logic                  w_avail_ok;
  logic                  w_last_beat;
  logic                  w_fifo_empty;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_reserved   = {1'b0, w_count} + {{PW{1'b0}}, r_cap_valid};
  assign w_space_ok   = (w_reserved <= SPACE_LIMIT);
  assign w_avail_ok   = (ti_out_available >= CNT_WIDTH'(BLOCK_LEN));
  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign w_fifo_empty = (w_count == '0);
  assign w_rd         = !w_fifo_empty && m_ready;
  assign w_head       = r_mem[r_rd_ptr[AW-1:0]];

  // Head is forced to zero while empty so the port reads 0 out of reset.
  assign m_valid      = !w_fifo_empty;
  assign m_data       = w_fifo_empty ? '0 : w_head;
  assign word_count   = r_word_count;
  assign checksum     = r_checksum;

  // State register
  always_ff @(posedge ti_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (num_blocks == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          w_next = S_DRAIN;
        end else if (w_avail_ok && w_space_ok) begin
          w_next = S_BURST;
        end
      end
      S_BURST: begin
        if (abort) begin
          w_next = S_DRAIN;
        end else if (w_last_beat) begin
          w_next = (r_blocks_left == CNT_WIDTH'(1)) ? S_DRAIN : S_WAIT;
        end
      end
      S_DRAIN: begin
        if (!r_cap_valid && w_fifo_empty) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    ti_out_data_en = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (r_state)
      S_IDLE:  busy = 1'b0;
      S_BURST: begin
        ti_out_data_en = 1'b1;
        busy           = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // Burst bookkeeping and capture of the word returned one cycle after a strobe
  always_ff @(posedge ti_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_blocks_left <= '0;
      r_beat        <= '0;
      r_cap_valid   <= 1'b0;
    end else begin
      r_cap_valid <= ti_out_data_en;
      if (r_state == S_IDLE && start) begin
        r_blocks_left <= num_blocks;
      end else if (r_state == S_BURST && w_last_beat && !abort) begin
        r_blocks_left <= r_blocks_left - CNT_WIDTH'(1);
      end
      if (r_state == S_BURST && !w_last_beat) begin
        r_beat <= r_beat + BW'(1);
      end else begin
        r_beat <= '0;
      end
    end
  end

  // FIFO pointers; the write side never checks full because space was reserved
  always_ff @(posedge ti_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (r_cap_valid) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge ti_clk) begin
    if (r_cap_valid) begin
      r_mem[r_wr_ptr[AW-1:0]] <= ti_out_data;
    end
  end

  // Delivery statistics, cleared when a transfer is accepted
  always_ff @(posedge ti_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_word_count <= '0;
      r_checksum   <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_word_count <= '0;
      r_checksum   <= '0;
    end else if (w_rd) begin
      r_word_count <= r_word_count + CNT_WIDTH'(1);
      r_checksum   <= r_checksum + w_head;
    end
  end

endmodule

// File: tb/tb_pipe_out_block_reader.sv
// tb/tb_pipe_out_block_reader.sv - randomized and directed bench for pipe_out_block_reader
`timescale 1ns/1ps

module tb_pipe_out_block_reader;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int BL = 16;
  localparam int BD = 32;

  logic          ti_clk = 1'b0;
  logic          a_rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b0;
  logic [CW-1:0] num_blocks = '0;
  logic [CW-1:0] ti_out_available = '0;
  logic [DW-1:0] ti_out_data = '0;
  logic          ti_out_data_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_count;
  logic [DW-1:0] checksum;

  always #5 ti_clk = ~ti_clk;

  pipe_out_block_reader #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .BLOCK_LEN(BL), .BUF_DEPTH(BD)
  ) dut (
    .ti_clk(ti_clk), .a_rst_n(a_rst_n), .start(start), .abort(abort),
    .num_blocks(num_blocks), .ti_out_available(ti_out_available),
    .ti_out_data_en(ti_out_data_en), .ti_out_data(ti_out_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .word_count(word_count), .checksum(checksum)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: words the producer has handed over but the consumer has not taken
  logic [DW-1:0] q[$];
  bit            pend;
  int            gen_idx;
  logic [DW-1:0] seq_base = '0;
  bit            use_seq = 1'b0;
  bit            m_busy, m_aborted, prev_done, prev_en;
  int            run;
  int            strobes;
  logic [CW-1:0] m_nb, prev_avail;
  logic [CW-1:0] mc;
  logic [DW-1:0] ms;
  bit            rnd_ready = 1'b0;
  bit            rnd_avail = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend = 0; gen_idx = 0; m_busy = 0; m_aborted = 0; prev_done = 0; prev_en = 0;
    run = 0; strobes = 0; m_nb = '0; prev_avail = '0; mc = '0; ms = '0;
  endtask

  // Called once per cycle at the falling edge: outputs are those of the
  // current cycle, inputs are those the next rising edge will sample.
  task automatic step();
    logic [DW-1:0] w;
    bit acc;
    if (!a_rst_n) return;
    chk("busy", busy, m_busy);
    chk("m_valid", m_valid, q.size() != 0);
    if (m_valid && q.size() != 0) chk("m_data", m_data, q[0]);
    chk("word_count", word_count, mc);
    chk("checksum", checksum, ms);
    if (ti_out_data_en) begin
      chk("en_while_idle", m_busy, 1);
      if (!prev_en) chk("avail_at_burst", prev_avail >= CW'(BL), 1);
      run++;
    end else if (run != 0) begin
      if (!m_aborted) chk("burst_len", run, BL);
      run = 0;
    end
    chk("occupancy", (q.size() + int'(pend)) <= BD, 1);
    if (done) begin
      chk("done_width", prev_done, 0);
      chk("drained", q.size(), 0);
      if (m_aborted) chk("strobes_le", strobes <= int'(m_nb) * BL, 1);
      else           chk("strobes", strobes, int'(m_nb) * BL);
    end
    // consumer side, taken from the words present before this cycle's capture
    if (m_valid && m_ready && q.size() != 0) begin
      ms = ms + q[0];
      mc = mc + CW'(1);
      void'(q.pop_front());
    end
    // producer side: answer the previous cycle's strobe, garbage otherwise
    if (pend) begin
      w = use_seq ? DW'(int'(seq_base) + gen_idx) : DW'($urandom);
      gen_idx++;
      q.push_back(w);
      ti_out_data = w;
    end else begin
      ti_out_data = DW'($urandom);
    end
    pend = ti_out_data_en;
    if (ti_out_data_en) strobes++;
    if (abort && m_busy) m_aborted = 1;
    acc = start && !m_busy;
    if (done) m_busy = 0;
    if (acc) begin
      m_busy = 1; mc = '0; ms = '0; strobes = 0; gen_idx = 0; m_aborted = 0;
      m_nb = num_blocks; run = 0;
    end
    prev_done  = done;
    prev_en    = ti_out_data_en;
    prev_avail = ti_out_available;
  endtask

  task automatic tick();
    @(negedge ti_clk);
    step();
    @(posedge ti_clk);
    #1;
    if (rnd_ready) m_ready = $urandom_range(0, 1) == 1;
    if (rnd_avail) ti_out_available = CW'($urandom_range(0, 40));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go(input int nb);
    start = 1'b1;
    num_blocks = CW'(nb);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int i;
    i = 0;
    while (!done && i < bound) begin
      tick();
      i++;
    end
    chk({name, "_done"}, done, 1);
  endtask

  initial begin
    int k, nb, d;
    model_reset();
    repeat (3) @(posedge ti_clk);
    #1;
    chk("rst_en", ti_out_data_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    a_rst_n = 1'b1;
    m_ready = 1'b1;
    ti_out_available = CW'(16);
    ticks(2);

    // Single block, data 1..16
    use_seq = 1; seq_base = DW'(1);
    go(1);
    wait_done("single", 200);
    chk("single_wc", word_count, 16);
    chk("single_cs", checksum, 136);
    chk("single_strobes", strobes, 16);
    ticks(2);

    // Throttle: producer short of a block for 20 cycles
    ti_out_available = CW'(10);
    go(3);
    ticks(20);
    chk("throttle_no_en", strobes, 0);
    ti_out_available = CW'(48);
    wait_done("throttle", 400);
    chk("throttle_wc", word_count, 48);
    chk("throttle_cs", checksum, 1176);
    ticks(2);

    // Backpressure: buffer fills after two bursts
    use_seq = 0;
    ti_out_available = CW'(64);
    m_ready = 1'b0;
    go(4);
    ticks(120);
    chk("bp_strobes", strobes, 32);
    chk("bp_valid", m_valid, 1);
    chk("bp_wc", word_count, 0);
    m_ready = 1'b1;
    wait_done("bp", 400);
    chk("bp_wc_final", word_count, 64);
    ticks(2);

    // Abort on the 5th strobe of block 1
    go(2);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (ti_out_data_en) k++;
      if (k == 5) break;
      tick();
    end
    chk("abort_reach5", k, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_en_drop", ti_out_data_en, 0);
    wait_done("abort", 200);
    chk("abort_wc", word_count, 5);
    chk("abort_strobes", strobes, 5);
    ticks(2);

    // Zero blocks: DONE immediately, no strobes
    go(0);
    chk("zero_done", done, 1);
    chk("zero_en", ti_out_data_en, 0);
    tick();
    chk("zero_done_clear", done, 0);
    chk("zero_busy_clear", busy, 0);
    chk("zero_wc", word_count, 0);
    ticks(2);

    // Checksum wrap, plus a start while busy that must be ignored
    use_seq = 1; seq_base = DW'(16'hFFF0);
    go(1);
    ticks(3);
    start = 1'b1; num_blocks = CW'(5);
    tick();
    start = 1'b0;
    wait_done("wrap", 200);
    chk("wrap_wc", word_count, 16);
    chk("wrap_cs", checksum, 16'hFF78);
    chk("wrap_strobes", strobes, 16);
    ticks(2);

    // Reset in the middle of a burst
    use_seq = 0;
    go(2);
    for (int i = 0; i < 50 && !ti_out_data_en; i++) tick();
    ticks(6);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("arst_en", ti_out_data_en, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_data", m_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_wc", word_count, 0);
    chk("arst_cs", checksum, 0);
    model_reset();
    ticks(2);
    a_rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", m_valid, 0);

    // Randomized transfers with random ready, availability and aborts
    rnd_ready = 1; rnd_avail = 1;
    for (int t = 0; t < 12; t++) begin
      nb = $urandom_range(1, 4);
      go(nb);
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom_range(1, 60);
        for (int i = 0; i < d; i++) begin
          if (done) break;
          tick();
        end
        if (!done) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
        end
      end
      wait_done("rand", 3000);
      ticks($urandom_range(1, 4));
    end
    rnd_ready = 0; rnd_avail = 0;
    m_ready = 1'b1;
    ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
